mac_pipe: RTL

//  Parametrised pipelined multiply-accumulate unit; next generation of the part2 square-accumulator.
//  - Takes two operands (a, b) per valid cycle and accumulates a*b into f.
//  - Adds a configurable multiply pipeline stage, an accumulator clear and a sticky overflow flag.
//  - Sits between a sample source (valid_in strobe) and a result consumer (valid_out strobe).

---
 rtl/mac_pipe.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mac_pipe.sv
// mac_pipe: pipelined unsigned multiply-accumulate.
//   Stage 1 captures operands, stage M (PIPE_MULT=1 only) registers the
//   product, and stage A accumulates into f with a sticky overflow flag.
//   Latency from valid_in to valid_out is 2+PIPE_MULT cycles. There is no
//   backpressure, so one sample can be accepted every cycle.
// Build option: define MAC_PIPE_SATURATE_EN to clamp f at all-ones on
//   overflow. Without it, f wraps modulo 2^ACC_W.
// ACC_W must be >= 2*IN_W so that a single product always fits in f.
module mac_pipe #(
  parameter int IN_W      = 8,
  parameter int ACC_W     = 20,
  parameter int PIPE_MULT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  input  logic             valid_in,
  input  logic             clear_acc,
  output logic [ACC_W-1:0] f,
  output logic             valid_out,
  output logic             overflow
);

  localparam int PW = 2 * IN_W;

  logic [IN_W-1:0]  a_r, b_r;
  logic             clr_r, v1;
  logic [PW-1:0]    prod_c;

  // Values seen by the accumulate stage (registered or direct, per PIPE_MULT)
  logic [PW-1:0]    prod_a;
  logic             clr_a, v_a;

  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] f_nxt;
  logic             ovf_nxt;

  // Stage 1: capture operands on valid samples; the valid bit tracks every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r   <= '0;
      b_r   <= '0;
      clr_r <= 1'b0;
      v1    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every stage reading the previous
      // cycle's values, whatever order the blocks happen to be evaluated in.
      v1 <= valid_in;
      if (valid_in) begin
        a_r   <= a;
        b_r   <= b;
        clr_r <= clear_acc;
      end
    end
  end

  assign prod_c = PW'(a_r) * PW'(b_r);

  generate
    if (PIPE_MULT != 0) begin : g_mult_reg
      logic [PW-1:0] prod_m;
      logic          clr_m, v_m;

      // Stage M: register the product to break the multiply-add path
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          prod_m <= '0;
          clr_m  <= 1'b0;
          v_m    <= 1'b0;
        end else begin
          v_m <= v1;
          if (v1) begin
            prod_m <= prod_c;
            clr_m  <= clr_r;
          end
        end
      end

      assign prod_a = prod_m;
      assign clr_a  = clr_m;
      assign v_a    = v_m;
    end else begin : g_mult_comb
      assign prod_a = prod_c;
      assign clr_a  = clr_r;
      assign v_a    = v1;
    end
  endgenerate

  // Stage A next-state: clear, accumulate, or hold; overflow is detected on the carry-out
  always_comb begin
    // NOTE: default every output first so no path through the block can infer a latch.
    f_nxt   = f;
    ovf_nxt = overflow;
    sum     = (ACC_W+1)'(f) + (ACC_W+1)'(prod_a);
    if (v_a) begin
      if (clr_a) begin
        f_nxt   = ACC_W'(prod_a);
        ovf_nxt = 1'b0;
      end else if (sum[ACC_W]) begin
        ovf_nxt = 1'b1;
`ifdef MAC_PIPE_SATURATE_EN
        f_nxt   = '1;
`else
        f_nxt   = sum[ACC_W-1:0];
`endif
      end else begin
        f_nxt = sum[ACC_W-1:0];
      end
    end
  end

  // Stage A register: accumulator, sticky flag, and output strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f         <= '0;
      overflow  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      f         <= f_nxt;
      overflow  <= ovf_nxt;
      valid_out <= v_a;
    end
  end

endmodule
